// File: rtl/dm_arbiter_if.sv
// Requester/memory bundle for the two-port data-memory arbiter.
interface dm_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              mem_read_en;
    logic              mem_write_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1,
        input  wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_read_en, mem_write_en, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1,
        output wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_read_en, mem_write_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory.
// Define DM_ARB_ROUND_ROBIN_EN for round-robin ties (default: port 0 wins).
module dm_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic         clock,
    input  logic         rst_n,
    dm_arbiter_if.slave  bus
);

`ifdef DM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    logic              owner;
    logic              last;
    logic              cmd_we;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;

    logic              pick1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // A tie goes to port 1 only when round-robin is on and port 0 was last.
    always_comb begin
        pick1     = bus.req1 && (!bus.req0 || (RR && !last));
        sel_we    = pick1 ? bus.we1 : bus.we0;
        sel_addr  = pick1 ? bus.addr1 : bus.addr0;
        sel_wdata = pick1 ? bus.wdata1 : bus.wdata0;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= 1'b0;
            last    <= 1'b1;
            cmd_we  <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rd_en   <= 1'b0;
            wr_en   <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rd_en   <= 1'b0;
            wr_en   <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            unique case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        owner   <= pick1;
                        last    <= pick1;
                        cmd_we  <= sel_we;
                        gnt0    <= !pick1;
                        gnt1    <= pick1;
                        rd_en   <= !sel_we;
                        wr_en   <= sel_we;
                        m_addr  <= sel_addr;
                        m_wdata <= sel_wdata;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_we) begin
                        state <= IDLE;
                    end else begin
                        rvalid0 <= !owner;
                        rvalid1 <= owner;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory read data is registered, so it is only valid during RESP.
    assign bus.rdata0       = rvalid0 ? bus.mem_rdata : '0;
    assign bus.rdata1       = rvalid1 ? bus.mem_rdata : '0;
    assign bus.gnt0         = gnt0;
    assign bus.gnt1         = gnt1;
    assign bus.rvalid0      = rvalid0;
    assign bus.rvalid1      = rvalid1;
    assign bus.mem_read_en  = rd_en;
    assign bus.mem_write_en = wr_en;
    assign bus.mem_addr     = m_addr;
    assign bus.mem_wdata    = m_wdata;

endmodule
